// File: rtl/ps2_arrow_decoder.sv
// PS/2 (scan code set 2) receiver that keeps a level-held image of the four arrow keys.
// Optional WASD_EN macro: non-extended W/S/A/D keys also drive key[3:0].
module ps2_arrow_decoder #(
  parameter int TIMEOUT_CYCLES = 130000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scan_code,
  output logic       byte_strobe,
  output logic       rx_error
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  // Arrow keys are extended codes; one-hot in key bit order UP, DOWN, LEFT, RIGHT.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    case (code)
      8'h75:   arrow_mask = 4'b0001;
      8'h72:   arrow_mask = 4'b0010;
      8'h6B:   arrow_mask = 4'b0100;
      8'h74:   arrow_mask = 4'b1000;
      default: arrow_mask = 4'b0000;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers; idle bus level is high, so reset to 1 to avoid a
  // phantom falling edge straight out of reset.
  // ---------------------------------------------------------------------------
  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_fall;
  logic       data_s;

  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      // NOTE: non-blocking assignments keep each register stage one cycle apart.
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_fall = clk_sync[2] & ~clk_sync[1];
  assign data_s   = data_sync[1];

  // ---------------------------------------------------------------------------
  // Frame receiver and watchdog. shreg collects start, D0..D7, parity with the
  // oldest bit at [0]; the stop bit is checked straight from data_s.
  // ---------------------------------------------------------------------------
  logic [3:0]      bit_cnt;
  logic [9:0]      shreg;
  logic [WD_W-1:0] wd_cnt;
  logic            frame_ok;

  assign frame_ok = ~shreg[0] & data_s & (^shreg[9:1]);

  always_ff @(posedge pclk) begin
    if (rst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      wd_cnt      <= '0;
      scan_code   <= '0;
      byte_strobe <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      rx_error    <= 1'b0;
      if (clk_fall) begin
        wd_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            scan_code   <= shreg[8:1];
            byte_strobe <= 1'b1;
          end else begin
            rx_error <= 1'b1;
          end
        end else begin
          shreg   <= {data_s, shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (wd_cnt == WD_LAST) begin
          bit_cnt  <= '0;
          wd_cnt   <= '0;
          rx_error <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix/break decoder. Any receive error drops a half-seen sequence.
  // ---------------------------------------------------------------------------
  state_t     state;
  logic [3:0] arrows;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state  <= IDLE;
      arrows <= '0;
    end else if (rx_error) begin
      state <= IDLE;
    end else if (byte_strobe) begin
      case (state)
        IDLE: begin
          if (scan_code == CODE_EXT)        state <= EXT;
          else if (scan_code == CODE_BREAK) state <= BRK;
          else                              state <= IDLE;
        end
        EXT: begin
          if (scan_code == CODE_BREAK)    state <= EXT_BRK;
          else if (scan_code == CODE_EXT) state <= EXT;
          else begin
            arrows <= arrows | arrow_mask(scan_code);
            state  <= IDLE;
          end
        end
        EXT_BRK: begin
          arrows <= arrows & ~arrow_mask(scan_code);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WASD_EN
  function automatic logic [3:0] wasd_mask(input logic [7:0] code);
    case (code)
      8'h1D:   wasd_mask = 4'b0001;
      8'h1B:   wasd_mask = 4'b0010;
      8'h1C:   wasd_mask = 4'b0100;
      8'h23:   wasd_mask = 4'b1000;
      default: wasd_mask = 4'b0000;
    endcase
  endfunction

  logic [3:0] wasd;

  // Shares the decoder's view of state, so it sees the same make/break context.
  always_ff @(posedge pclk) begin
    if (rst) begin
      wasd <= '0;
    end else if (byte_strobe && !rx_error) begin
      if (state == IDLE)     wasd <= wasd | wasd_mask(scan_code);
      else if (state == BRK) wasd <= wasd & ~wasd_mask(scan_code);
    end
  end

  assign key = arrows | wasd;
`else
  assign key = arrows;
`endif

endmodule
